uart_tx_feeder: RTL and testbench
=================================

Name: uart_tx_feeder

Overview:
- Upstream companion of the UART transmitter FSM.
- Accepts a byte-wide write stream from the host and packs bytes little-endian into DATA_WIDTH words. Byte 0 goes in bits [7:0], so it is transmitted first, LSB-first.
- Buffers packed words with a per-word error-inject flag in a small FIFO.
- Presents each word to the transmitter through its valid/ready/data/error inputs.

Parameters:
- DATA_WIDTH, 8, transmitter word width; must be a multiple of 8 and ≥8. BYTES = DATA_WIDTH/8.
- DEPTH, 4, number of FIFO word entries; must be a power of 2 and ≥2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wr_valid  in  1  host byte write request
- wr_ready  out  1  feeder can accept the current byte
- wr_byte  in  8  byte data
- wr_err_inject  in  1  request inverted parity for the word containing this byte
- flush  in  1  push a partially packed word, zero-padded
- tx_valid  out  1  word available to the transmitter
- tx_ready  in  1  transmitter idle/ready
- tx_data  out  DATA_WIDTH  head word
- tx_error  out  1  head word error-inject flag
- level  out  $clog2(DEPTH)+1  FIFO occupancy in words
- empty  out  1  level==0
- full  out  1  level==DEPTH

Behaviour:
- Reset (async, rst_n low):
  - Clears pointers, level, packer byte index, packer data and packer error accumulator.
  - Outputs during and after reset: tx_valid=0, tx_data=0, tx_error=0, level=0, empty=1, full=0, wr_ready=1.
  - Reset mid-operation discards buffered and partial words. No partial push occurs.
- Packer:
  - Byte accepted when wr_valid && wr_ready.
  - Accepted byte is written to slot byte_idx (bits byte_idx*8 +: 8). byte_idx increments, wrapping at BYTES.
  - err_acc accumulates the OR of wr_err_inject across the bytes of the word.
- Word push:
  - On acceptance of the byte at byte_idx==BYTES-1, the completed word and flag (err_acc | wr_err_inject) are pushed in the same cycle.
  - The push then clears byte_idx, err_acc and packer data.
- wr_ready = !full || (byte_idx != BYTES-1).
  - With BYTES==1 this reduces to !full.
- Flush:
  - flush && byte_idx!=0 && !full pushes the partial word; unwritten upper bytes are 0. The packer is then cleared.
  - flush with byte_idx==0 is a no-op.
  - flush while full with byte_idx!=0 stalls: it must be held until !full.
  - flush together with an accepted byte: the byte is included first. If that byte completes the word, exactly one push occurs.
- FIFO:
  - Circular buffer with ADDR=$clog2(DEPTH)-bit pointers and a separate level counter.
  - Push when full is impossible by construction.
  - Simultaneous push and pop leaves level unchanged. Both pointers advance and wrap from DEPTH-1 to 0.
- Transmitter handshake:
  - tx_valid = !empty && tx_ready (combinational).
  - Pop on tx_valid; the transmitter samples data and error in that cycle.
  - The transmitter drops tx_ready during a frame and re-raises it only after one idle cycle with tx_valid low. Gating by tx_ready therefore guarantees exactly one pop per frame and no back-to-back double accept.
  - tx_data/tx_error show the head entry when !empty, and 0 when empty.
- Latency:
  - A pushed word appears at the head one cycle after the push. There is no write-to-read bypass.
  - If the FIFO was empty, tx_valid can rise at the earliest the cycle after the push.

Optional Feature:
- Macro UART_TX_FEEDER_STATS_EN.
- When defined, adds outputs words_sent [15:0] and err_words_sent [15:0]:
  - Both reset to 0.
  - words_sent increments on each pop; err_words_sent increments on each pop with tx_error=1.
  - Both wrap 0xFFFF to 0.
- When undefined, these ports and counters do not exist and all other behaviour is identical.

Test Plan:
- DATA_WIDTH=16: write 0x34 then 0x12, no err, tx_ready=1 → one pop with tx_data=0x1234, tx_error=0; level back to 0.
- DATA_WIDTH=16: write 0xAA with wr_err_inject=1, then 0x55 with 0 → tx_data=0x55AA, tx_error=1.
- DATA_WIDTH=32: write 0x11, then pulse flush → pushes 0x00000011; flush with byte_idx==0 → no push, level unchanged.
- DATA_WIDTH=8, DEPTH=4, tx_ready=0: write 5 bytes → first 4 accepted; full=1, wr_ready=0 on the 5th. Raise tx_ready → order preserved 1,2,3,4 then 5; pointers wrap.
- tx_ready pattern 1,0(×10),1: FIFO holds 2 words → exactly one pop per tx_ready-high window. Simultaneous push and pop keeps level constant.
- Assert rst_n=0 mid-packing with 3 words buffered → level=0, empty=1, tx_valid=0 immediately. The next byte lands in slot 0.

Source files
------------

// File: rtl/uart_tx_feeder.sv
// Byte-to-word packer and word FIFO feeding the UART transmitter FSM.
// Optional statistics counters are enabled by defining UART_TX_FEEDER_STATS_EN.
module uart_tx_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [7:0]                wr_byte,
    input  logic                      wr_err_inject,
    input  logic                      flush,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic [DATA_WIDTH-1:0]     tx_data,
    output logic                      tx_error,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      empty,
    output logic                      full
`ifdef UART_TX_FEEDER_STATS_EN
    ,
    output logic [15:0]               words_sent,
    output logic [15:0]               err_words_sent
`endif
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int ADDR  = $clog2(DEPTH);
    localparam int LVLW  = ADDR + 1;
    localparam int IDXW  = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [IDXW-1:0]       byte_idx;
    logic [IDXW-1:0]       idx_inc;
    logic [IDXW-1:0]       idx_after;
    logic [DATA_WIDTH-1:0] pack_data;
    logic [DATA_WIDTH-1:0] merged_data;
    logic                  err_acc;
    logic                  merged_err;
    logic                  last_byte;
    logic                  accept;
    logic                  push_word;
    logic                  push_flush;
    logic                  push;
    logic                  pop;

    logic [DATA_WIDTH-1:0] mem_data [DEPTH];
    logic                  mem_err  [DEPTH];
    logic [ADDR-1:0]       wr_ptr;
    logic [ADDR-1:0]       rd_ptr;

    assign full      = (level == LVLW'(DEPTH));
    assign empty     = (level == '0);
    assign last_byte = (byte_idx == IDXW'(BYTES - 1));
    assign wr_ready  = !full || !last_byte;
    assign accept    = wr_valid && wr_ready;
    assign idx_inc   = last_byte ? '0 : byte_idx + IDXW'(1);

    // The accepted byte is merged first so a same-cycle flush or completion sees it.
    always_comb begin
        merged_data = pack_data;
        for (int i = 0; i < BYTES; i++) begin
            if (accept && (byte_idx == IDXW'(i))) begin
                merged_data[i*8 +: 8] = wr_byte;
            end
        end
        merged_err = err_acc | (accept & wr_err_inject);
        idx_after  = accept ? idx_inc : byte_idx;
    end

    assign push_word  = accept && last_byte;
    assign push_flush = flush && !full && (idx_after != '0);
    assign push       = push_word || push_flush;

    assign tx_valid = !empty && tx_ready;
    assign pop      = tx_valid;
    assign tx_data  = empty ? '0 : mem_data[rd_ptr];
    assign tx_error = !empty && mem_err[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx  <= '0;
            pack_data <= '0;
            err_acc   <= 1'b0;
        end else if (push) begin
            byte_idx  <= '0;
            pack_data <= '0;
            err_acc   <= 1'b0;
        end else if (accept) begin
            byte_idx  <= idx_inc;
            pack_data <= merged_data;
            err_acc   <= merged_err;
        end
    end

    // Storage carries no reset; the empty gating on tx_data/tx_error hides stale entries.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= merged_data;
            mem_err[wr_ptr]  <= merged_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVLW'(1);
                2'b01:   level <= level - LVLW'(1);
                default: level <= level;
            endcase
        end
    end

`ifdef UART_TX_FEEDER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_sent     <= '0;
            err_words_sent <= '0;
        end else if (pop) begin
            words_sent <= words_sent + 16'd1;
            if (tx_error) begin
                err_words_sent <= err_words_sent + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: 8/16/32-bit instances, vector table, directed sequences, random vs queue model.
module tb_uart_tx_feeder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       wv [3];
    logic       wi [3];
    logic       fl [3];
    logic       tr [3];
    logic [7:0] wb [3];
    logic       wrdy [3];
    logic       tv [3];
    logic       te [3];
    logic       emp [3];
    logic       ful [3];
    logic [2:0] lvl [3];
    logic [7:0]  td8;
    logic [15:0] td16;
    logic [31:0] td32;

    int n_cmp = 0;
    int n_bad = 0;
    int nb [3] = '{1, 2, 4};

    uart_tx_feeder #(.DATA_WIDTH(8), .DEPTH(4)) u_w8 (
        .clk(clk), .rst_n(rst_n), .wr_valid(wv[0]), .wr_ready(wrdy[0]), .wr_byte(wb[0]),
        .wr_err_inject(wi[0]), .flush(fl[0]), .tx_valid(tv[0]), .tx_ready(tr[0]),
        .tx_data(td8), .tx_error(te[0]), .level(lvl[0]), .empty(emp[0]), .full(ful[0]));

    uart_tx_feeder #(.DATA_WIDTH(16), .DEPTH(4)) u_w16 (
        .clk(clk), .rst_n(rst_n), .wr_valid(wv[1]), .wr_ready(wrdy[1]), .wr_byte(wb[1]),
        .wr_err_inject(wi[1]), .flush(fl[1]), .tx_valid(tv[1]), .tx_ready(tr[1]),
        .tx_data(td16), .tx_error(te[1]), .level(lvl[1]), .empty(emp[1]), .full(ful[1]));

    uart_tx_feeder #(.DATA_WIDTH(32), .DEPTH(4)) u_w32 (
        .clk(clk), .rst_n(rst_n), .wr_valid(wv[2]), .wr_ready(wrdy[2]), .wr_byte(wb[2]),
        .wr_err_inject(wi[2]), .flush(fl[2]), .tx_valid(tv[2]), .tx_ready(tr[2]),
        .tx_data(td32), .tx_error(te[2]), .level(lvl[2]), .empty(emp[2]), .full(ful[2]));

    function automatic logic [39:0] snap(input int k);
        logic [31:0] d;
        case (k)
            0:       d = {24'h0, td8};
            1:       d = {16'h0, td16};
            default: d = td32;
        endcase
        return {wrdy[k], tv[k], te[k], emp[k], ful[k], lvl[k], d};
    endfunction

    function automatic logic [39:0] expv(input bit er, input bit ev, input logic [31:0] ed,
                                         input bit ee, input int el);
        return {er, ev, ee, (el == 0), (el == 4), 3'(el), ed};
    endfunction

    task automatic compare(input string nm, input int k, input logic [39:0] exp);
        logic [39:0] got;
        got = snap(k);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d got {rdy,vld,err,empty,full,level,data}=%h expected=%h",
                     nm, k, got, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, check outputs shortly after.
    task automatic cyc(input int k, input bit v, input logic [7:0] b, input bit i, input bit f,
                       input bit t, input bit er, input bit ev, input logic [31:0] ed,
                       input bit ee, input int el, input string nm);
        @(negedge clk);
        wv[k] = v; wb[k] = b; wi[k] = i; fl[k] = f; tr[k] = t;
        #1;
        compare(nm, k, expv(er, ev, ed, ee, el));
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < 3; k++) begin
            wv[k] = 1'b0; wb[k] = 8'h0; wi[k] = 1'b0; fl[k] = 1'b0; tr[k] = 1'b0;
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference model: a queue of words plus a list of pending bytes.
    logic [31:0] mq_d [$];
    bit          mq_e [$];
    logic [7:0]  mp   [$];
    bit          mp_e;

    task automatic rand_run(input int k, input int n);
        bit v, i, f, t, mfull, e_rdy, e_v, e_e;
        logic [7:0]  b;
        logic [31:0] e_d, w;
        mq_d.delete(); mq_e.delete(); mp.delete(); mp_e = 0;
        for (int c = 0; c < n; c++) begin
            v = ($urandom_range(0, 9) < 7);
            b = 8'($urandom);
            i = ($urandom_range(0, 4) == 0);
            f = ($urandom_range(0, 9) == 0);
            t = 1'($urandom_range(0, 1));
            mfull = (mq_d.size() == 4);
            e_rdy = !mfull || (mp.size() != nb[k] - 1);
            e_v   = (mq_d.size() != 0) && t;
            e_d   = (mq_d.size() != 0) ? mq_d[0] : 32'h0;
            e_e   = (mq_d.size() != 0) ? mq_e[0] : 1'b0;
            cyc(k, v, b, i, f, t, e_rdy, e_v, e_d, e_e, mq_d.size(), "random");
            if (e_v) begin
                void'(mq_d.pop_front());
                void'(mq_e.pop_front());
            end
            if (v && e_rdy) begin
                mp.push_back(b);
                mp_e = mp_e | i;
            end
            if (mp.size() == nb[k] || (f && mp.size() != 0 && !mfull)) begin
                w = 32'h0;
                foreach (mp[j]) w = w | (32'(mp[j]) << (8 * j));
                mq_d.push_back(w);
                mq_e.push_back(mp_e);
                mp.delete();
                mp_e = 0;
            end
        end
    endtask

    typedef struct {
        bit         v;
        logic [7:0] b;
        bit         t;
        bit         er;
        bit         ev;
        logic [7:0] ed;
        int         el;
    } vec_t;

    vec_t tbl [11];

    initial begin
        tbl[0]  = '{1, 8'h01, 0, 1, 0, 8'h00, 0};
        tbl[1]  = '{1, 8'h02, 0, 1, 0, 8'h01, 1};
        tbl[2]  = '{1, 8'h03, 0, 1, 0, 8'h01, 2};
        tbl[3]  = '{1, 8'h04, 0, 1, 0, 8'h01, 3};
        tbl[4]  = '{1, 8'h05, 0, 0, 0, 8'h01, 4};
        tbl[5]  = '{1, 8'h05, 1, 0, 1, 8'h01, 4};
        tbl[6]  = '{1, 8'h05, 1, 1, 1, 8'h02, 3};
        tbl[7]  = '{0, 8'h00, 1, 1, 1, 8'h03, 3};
        tbl[8]  = '{0, 8'h00, 1, 1, 1, 8'h04, 2};
        tbl[9]  = '{0, 8'h00, 1, 1, 1, 8'h05, 1};
        tbl[10] = '{0, 8'h00, 0, 1, 0, 8'h00, 0};

        clear_inputs();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) compare("reset_state", k, expv(1, 0, 32'h0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;

        // Two-byte little-endian packing, with and without error injection.
        cyc(1, 1, 8'h34, 0, 0, 1, 1, 0, 32'h0, 0, 0, "pack16_b0");
        cyc(1, 1, 8'h12, 0, 0, 1, 1, 0, 32'h0, 0, 0, "pack16_b1");
        cyc(1, 0, 8'h00, 0, 0, 1, 1, 1, 32'h1234, 0, 1, "pack16_pop");
        cyc(1, 0, 8'h00, 0, 0, 0, 1, 0, 32'h0, 0, 0, "pack16_drained");
        cyc(1, 1, 8'hAA, 1, 0, 1, 1, 0, 32'h0, 0, 0, "err16_b0");
        cyc(1, 1, 8'h55, 0, 0, 1, 1, 0, 32'h0, 0, 0, "err16_b1");
        cyc(1, 0, 8'h00, 0, 0, 1, 1, 1, 32'h55AA, 1, 1, "err16_pop");
        cyc(1, 0, 8'h00, 0, 0, 0, 1, 0, 32'h0, 0, 0, "err16_drained");

        // Flush behaviour on the 32-bit instance.
        cyc(2, 1, 8'h11, 0, 0, 0, 1, 0, 32'h0, 0, 0, "flush32_byte");
        cyc(2, 0, 8'h00, 0, 1, 0, 1, 0, 32'h0, 0, 0, "flush32_partial");
        cyc(2, 0, 8'h00, 0, 1, 0, 1, 0, 32'h11, 0, 1, "flush32_idle_noop");
        cyc(2, 0, 8'h00, 0, 0, 0, 1, 0, 32'h11, 0, 1, "flush32_level_kept");
        cyc(2, 1, 8'hA1, 0, 0, 0, 1, 0, 32'h11, 0, 1, "flush32_a1");
        cyc(2, 1, 8'hA2, 0, 0, 0, 1, 0, 32'h11, 0, 1, "flush32_a2");
        cyc(2, 1, 8'hA3, 0, 0, 0, 1, 0, 32'h11, 0, 1, "flush32_a3");
        cyc(2, 1, 8'hA4, 0, 1, 0, 1, 0, 32'h11, 0, 1, "flush32_complete");
        cyc(2, 1, 8'hB1, 0, 1, 1, 1, 1, 32'h11, 0, 2, "flush32_byte_flush");
        cyc(2, 0, 8'h00, 0, 0, 1, 1, 1, 32'hA4A3A2A1, 0, 2, "flush32_single_push");
        cyc(2, 0, 8'h00, 0, 0, 1, 1, 1, 32'h000000B1, 0, 1, "flush32_b1");
        cyc(2, 0, 8'h00, 0, 0, 0, 1, 0, 32'h0, 0, 0, "flush32_drained");

        // Fill/overflow/drain table on the 8-bit instance.
        for (int r = 0; r < 11; r++) begin
            cyc(0, tbl[r].v, tbl[r].b, 0, 0, tbl[r].t, tbl[r].er, tbl[r].ev,
                {24'h0, tbl[r].ed}, 0, tbl[r].el, $sformatf("table_row%0d", r));
        end

        // One pop per tx_ready window, simultaneous push/pop holds level.
        cyc(0, 1, 8'h61, 0, 0, 0, 1, 0, 32'h00, 0, 0, "window_w0");
        cyc(0, 1, 8'h62, 0, 0, 0, 1, 0, 32'h61, 0, 1, "window_w1");
        cyc(0, 1, 8'h63, 0, 0, 1, 1, 1, 32'h61, 0, 2, "window_pushpop");
        for (int j = 0; j < 10; j++) cyc(0, 0, 8'h00, 0, 0, 0, 1, 0, 32'h62, 0, 2, "window_low");
        cyc(0, 0, 8'h00, 0, 0, 1, 1, 1, 32'h62, 0, 2, "window_pop2");
        cyc(0, 0, 8'h00, 0, 0, 0, 1, 0, 32'h63, 0, 1, "window_gap");
        cyc(0, 0, 8'h00, 0, 0, 1, 1, 1, 32'h63, 0, 1, "window_pop3");
        cyc(0, 0, 8'h00, 0, 0, 0, 1, 0, 32'h00, 0, 0, "window_drained");

        // Reset in the middle of packing with three words buffered.
        for (int j = 0; j < 7; j++) begin
            cyc(1, 1, 8'(j + 1), 0, 0, 0, 1, 0, (j < 2) ? 32'h0 : 32'h0201, 0, j / 2, "fill16");
        end
        @(negedge clk);
        wv[1] = 1'b0; tr[1] = 1'b1;
        rst_n = 1'b0;
        #1;
        compare("midreset_state", 1, expv(1, 0, 32'h0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 1, 8'h77, 0, 1, 0, 1, 0, 32'h0, 0, 0, "postreset_byte");
        cyc(1, 0, 8'h00, 0, 0, 1, 1, 1, 32'h0077, 0, 1, "postreset_slot0");
        cyc(1, 0, 8'h00, 0, 0, 0, 1, 0, 32'h0, 0, 0, "postreset_drained");

        // Randomized traffic against the queue model on every width.
        for (int k = 0; k < 3; k++) begin
            reset_pulse();
            rand_run(k, 250);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
